// File: rtl/aes_block_assembler.sv
// Packs DW-bit bytes (first byte in the MSB) into DW*BYTES-bit AES blocks behind a valid/ready output slot.
// Optional sticky overrun flag when AES_BLOCK_ASSEMBLER_OVERRUN_EN is defined.
module aes_block_assembler #(
  parameter int DW    = 8,
  parameter int BYTES = 16,
  parameter int CW    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  output logic                in_ready,
  output logic                blk_valid,
  output logic [DW*BYTES-1:0] blk_data,
  input  logic                blk_ready,
  output logic [CW-1:0]       fill_cnt
`ifdef AES_BLOCK_ASSEMBLER_OVERRUN_EN
  ,
  output logic                overrun
`endif
);

  localparam logic [CW-1:0] FULL_CNT = CW'(BYTES);

  logic [DW*BYTES-1:0] asm_p0;
  logic                full_p0;
  logic                slot_free;
  logic                load;
  logic                accept;
  logic [CW-1:0]       fill_nxt;

  always_comb begin
    full_p0   = (fill_cnt == FULL_CNT);
    slot_free = !blk_valid || blk_ready;
    load      = full_p0 && slot_free && !clr;
    accept    = in_valid && in_ready && !clr;
    fill_nxt  = fill_cnt;
    if (clr || load)
      fill_nxt = '0;
    else if (accept)
      fill_nxt = fill_cnt + CW'(1);
  end

  // Stage 0: assembly register; fill_cnt doubles as the FILLING/FULL state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt <= '0;
      in_ready <= 1'b1;
      asm_p0   <= '0;
    end else begin
      fill_cnt <= fill_nxt;
      in_ready <= (fill_nxt != FULL_CNT);
      if (clr)
        asm_p0 <= '0;
      else if (accept)
        for (int k = 0; k < BYTES; k++)
          if (fill_cnt == CW'(k))
            asm_p0[DW*(BYTES-1-k) +: DW] <= in_data;
    end
  end

  // Stage 1: output register, loaded the edge after the block completes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_valid <= 1'b0;
      blk_data  <= '0;
    end else if (load) begin
      blk_valid <= 1'b1;
      blk_data  <= asm_p0;
    end else if (blk_valid && blk_ready) begin
      blk_valid <= 1'b0;
    end
  end

`ifdef AES_BLOCK_ASSEMBLER_OVERRUN_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      overrun <= 1'b0;
    else if (clr)
      overrun <= 1'b0;
    else if (in_valid && !in_ready)
      overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_aes_block_assembler.sv
// Randomized + directed bench for aes_block_assembler: a byte-queue reference model feeds a block scoreboard.
module tb_aes_block_assembler;
  localparam int DW = 8, BYTES = 16, CW = 5, BW = DW*BYTES;

  logic clk = 1'b0, reset = 1'b1, clr = 1'b0, in_valid = 1'b0, blk_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, blk_valid;
  logic [BW-1:0] blk_data;
  logic [CW-1:0] fill_cnt;
`ifdef AES_BLOCK_ASSEMBLER_OVERRUN_EN
  logic overrun;
`endif

  aes_block_assembler #(.DW(DW), .BYTES(BYTES), .CW(CW)) dut (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .blk_valid(blk_valid), .blk_data(blk_data),
    .blk_ready(blk_ready), .fill_cnt(fill_cnt)
`ifdef AES_BLOCK_ASSEMBLER_OVERRUN_EN
    , .overrun(overrun)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [BW-1:0] exp_q[$];
  logic [DW-1:0] partial[$];
  bit out_v = 0, ovr = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [BW-1:0] fill_block(input logic [DW-1:0] b);
    logic [BW-1:0] r;
    for (int i = 0; i < BYTES; i++) r[DW*i +: DW] = b;
    return r;
  endfunction

  // Reference model: bytes collect in a queue; a full queue becomes a block once the output slot is free.
  always @(negedge clk) begin
    if (reset) begin
      partial.delete(); exp_q.delete(); out_v = 0; ovr = 0;
    end else begin
      bit full, pop, load;
      logic [BW-1:0] blk;
      full = (partial.size() == BYTES);
      chk("in_ready", BW'(in_ready), BW'(!full));
      chk("fill_cnt", BW'(fill_cnt), BW'(partial.size()));
      chk("blk_valid", BW'(blk_valid), BW'(out_v));
`ifdef AES_BLOCK_ASSEMBLER_OVERRUN_EN
      chk("overrun", BW'(overrun), BW'(ovr));
      if (clr) ovr = 0; else if (in_valid && full) ovr = 1;
`endif
      pop = out_v && blk_ready;
      load = 0;
      if (clr) partial.delete();
      else if (full && (!out_v || blk_ready)) begin
        for (int i = 0; i < BYTES; i++) blk[BW-DW*(i+1) +: DW] = partial[i];
        exp_q.push_back(blk);
        partial.delete();
        load = 1;
      end else if (in_valid && !full) partial.push_back(in_data);
      out_v = load ? 1'b1 : (pop ? 1'b0 : out_v);
    end
  end

  // Monitor: the presented block must match the oldest expected one for as long as it is shown.
  always @(negedge clk) begin
    if (!reset && blk_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL blk_unexpected: got %h expected none at %0t", blk_data, $time);
      end else begin
        chk("blk_data", blk_data, exp_q[0]);
        if (blk_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive(input bit v, input logic [DW-1:0] d, input bit r, input bit c);
    in_valid = v; in_data = d; blk_ready = r; clr = c;
    @(posedge clk); #1;
  endtask

  task automatic send_block(input logic [DW-1:0] base, input bit incr, input bit r);
    for (int i = 0; i < BYTES; i++) drive(1, incr ? base + DW'(i) : base, r, 0);
    drive(0, 0, r, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12 reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_in_ready", BW'(in_ready), BW'(1));
    chk("reset_blk_data", blk_data, '0);

    // single block 0x00..0x0F
    send_block(8'h00, 1, 1);
    drive(0, 0, 1, 0);

    // backpressure: A held in output, B held in assembly, extra bytes dropped
    send_block(8'hAA, 0, 0);
    send_block(8'hBB, 0, 0);
    drive(1, 8'hEE, 0, 0);
    drive(1, 8'hEF, 0, 0);
    chk("bp_hold_A", blk_data, fill_block(8'hAA));
    chk("bp_in_ready", BW'(in_ready), BW'(0));
    drive(0, 0, 1, 0);
    chk("bp_B_loaded", blk_data, fill_block(8'hBB));
    chk("bp_B_valid", BW'(blk_valid), BW'(1));
    chk("bp_ready_again", BW'(in_ready), BW'(1));
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 0);

    // streaming: continuous in_valid for three blocks
    for (int i = 0; i < 3*(BYTES+1); i++) drive(1, DW'(8'h40 + i), 1, 0);
    drive(0, 0, 1, 1);
    drive(0, 0, 1, 0);

    // clr mid-block
    for (int i = 0; i < 5; i++) drive(1, DW'(8'h80 + i), 1, 0);
    drive(1, 8'h99, 1, 1);
    chk("clr_fill_cnt", BW'(fill_cnt), '0);
    send_block(8'h10, 1, 1);
    chk("clr_block", blk_data, 128'h101112131415161718191A1B1C1D1E1F);
    drive(0, 0, 1, 0);

    // async reset with a pending output block and 7 bytes in assembly
    send_block(8'h55, 0, 0);
    for (int i = 0; i < 7; i++) drive(1, DW'(8'h60 + i), 0, 0);
    chk("pre_reset_fill", BW'(fill_cnt), BW'(7));
    #2 reset = 1'b1;
    #1;
    chk("areset_blk_valid", BW'(blk_valid), '0);
    chk("areset_fill_cnt", BW'(fill_cnt), '0);
    chk("areset_blk_data", blk_data, '0);
    @(posedge clk); #1 reset = 1'b0;
    drive(0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 800; i++)
      drive($urandom_range(99) < 70, DW'($urandom), $urandom_range(99) < 60, $urandom_range(99) < 2);
    for (int i = 0; i < 40; i++) drive(0, 0, 1, 0);
    chk("drained", BW'(exp_q.size()), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
